// File: rtl/nn_result_drain.sv
// nn_result_drain: starts a neural datapath job, waits for completion, then
// drains the z result buffer to host memory one 512-bit cache line at a time.
// After the data lines it writes a status line holding a done marker, the
// cycle count spent waiting for the datapath, and the error flags.
//
// Optional feature: define NN_DRAIN_TIMEOUT_EN to enable the nn_done watchdog.
// When enabled, a wait reaching TIMEOUT_CYCLES sets error flag bit 0 and jumps
// straight to the status write. When not defined, the wait is unbounded and
// the error flags stay 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_valid           one-cycle job start pulse (accepted only when idle)
//   cfg_base_addr[41:0] cache-line address of the result area
//   nn_start            one-cycle start strobe to the datapath
//   nn_done             datapath completion (level or pulse)
//   z_rd_addr           z buffer read address
//   z_dout[31:0]        z buffer read data, one cycle after z_rd_addr
//   wr_valid            host write request, one line per asserted cycle
//   wr_addr[41:0]       cache-line address of the write
//   wr_data[511:0]      write payload
//   wr_almfull          write channel back-pressure
//   busy                high while a job is in progress
//   job_done            one-cycle pulse alongside the status write
module nn_result_drain #(
  parameter int NUM_WORDS      = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_valid,
  input  logic [41:0]                  cfg_base_addr,
  output logic                         nn_start,
  input  logic                         nn_done,
  output logic [$clog2(NUM_WORDS)-1:0] z_rd_addr,
  input  logic [31:0]                  z_dout,
  output logic                         wr_valid,
  output logic [41:0]                  wr_addr,
  output logic [511:0]                 wr_data,
  input  logic                         wr_almfull,
  output logic                         busy,
  output logic                         job_done
);

  localparam int              AW         = $clog2(NUM_WORDS);
  localparam int              NUM_LINES  = NUM_WORDS / 16;
  localparam logic [AW-1:0]   LAST_LINE  = AW'(NUM_LINES - 1);
  localparam logic [41:0]     STATUS_OFS = 42'(NUM_LINES);
  localparam logic [32:0]     TIMEOUT_LIM = 33'(TIMEOUT_CYCLES);
`ifdef NN_DRAIN_TIMEOUT_EN
  localparam bit              TIMEOUT_EN = 1'b1;
`else
  localparam bit              TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, READ, WRITE, STATUS} state_t;

  state_t         state, state_nxt;
  logic [41:0]    base;
  logic [31:0]    cycle_cnt;
  logic [31:0]    cycle_cnt_inc;
  logic [31:0]    err_flags;
  logic [AW-1:0]  line_idx;
  logic [4:0]     word_idx;
  logic [3:0]     slot_p1;
  logic [511:0]   line_buf;
  logic [511:0]   status_line;
  logic           timeout_hit;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign cycle_cnt_inc = sat_inc(cycle_cnt);
  assign timeout_hit   = TIMEOUT_EN && ({1'b0, cycle_cnt_inc} >= TIMEOUT_LIM);
  assign status_line   = {384'h0, err_flags, cycle_cnt, 64'h1};

  // Read issue (p0): word_idx runs 0..16 in READ; only 0..15 address the
  // buffer, the value 16 is the extra cycle that lands the last word.
  assign z_rd_addr = (line_idx << 4) | AW'(word_idx[3:0]);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    nn_start  = 1'b0;
    wr_valid  = 1'b0;
    job_done  = 1'b0;
    wr_addr   = base + 42'(line_idx);
    wr_data   = line_buf;
    case (state)
      IDLE:      if (cfg_valid) state_nxt = START;
      START: begin
        nn_start  = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (nn_done)          state_nxt = READ;
        else if (timeout_hit) state_nxt = STATUS;
      end
      READ:      if (word_idx == 5'd16) state_nxt = WRITE;
      WRITE: begin
        if (!wr_almfull) begin
          wr_valid  = 1'b1;
          state_nxt = (line_idx == LAST_LINE) ? STATUS : READ;
        end
      end
      STATUS: begin
        wr_addr = base + STATUS_OFS;
        wr_data = status_line;
        if (!wr_almfull) begin
          wr_valid  = 1'b1;
          job_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cycle_cnt <= 32'd0;
      err_flags <= 32'd0;
      line_idx  <= '0;
      word_idx  <= 5'd0;
    end else begin
      state <= state_nxt;
      case (state)
        START: begin
          cycle_cnt <= 32'd0;
          err_flags <= 32'd0;
          line_idx  <= '0;
          word_idx  <= 5'd0;
        end
        WAIT_DONE: begin
          cycle_cnt <= cycle_cnt_inc;
          if (!nn_done && timeout_hit) err_flags[0] <= 1'b1;
        end
        READ:  if (word_idx != 5'd16) word_idx <= word_idx + 5'd1;
        WRITE: begin
          if (!wr_almfull) begin
            word_idx <= 5'd0;
            line_idx <= line_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Capture (p1): data for the address issued last cycle goes to the slot
  // one behind word_idx; at word_idx==16 this wraps to slot 15.
  assign slot_p1 = word_idx[3:0] - 4'd1;

  always_ff @(posedge clk) begin
    if (state == IDLE && cfg_valid) base <= cfg_base_addr;
    if (state == READ && word_idx != 5'd0) line_buf[{slot_p1, 5'b0} +: 32] <= z_dout;
  end

endmodule
